// File: rtl/instruction_memory_v3_if.sv
// Fetch/program-load bus between the controller/switch front end (master)
// and the instruction store (slave).
interface instruction_memory_v3_if #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 3
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              isexternal;
  logic [DATA_W-1:0] switches;
  logic              record;
  logic              prog_mode;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [ADDR_W-1:0] wr_ptr;
  logic              prog_full;
  logic              in_prog;

  modport master (
    output rd_en, rd_addr, isexternal, switches, record, prog_mode,
    input  rd_data, rd_valid, wr_ptr, prog_full, in_prog
  );

  modport slave (
    input  rd_en, rd_addr, isexternal, switches, record, prog_mode,
    output rd_data, rd_valid, wr_ptr, prog_full, in_prog
  );
endinterface

// File: rtl/instruction_memory_v3.sv
// Parametrised instruction store: registered fetch port with request/valid,
// edge-detected write strobe, and an auto-incrementing program-load mode.
// Optional build macro: DEFAULT_PROGRAM_EN loads the demo program at reset
// (needs DATA_W=12 and DEPTH>=8); otherwise every word resets to NOP_WORD.
module instruction_memory_v3 #(
  parameter int unsigned       DATA_W   = 12,
  parameter int unsigned       DEPTH    = 8,
  parameter int unsigned       ADDR_W   = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] NOP_WORD = {DATA_W{1'b1}}
) (
  input logic                   clk,
  input logic                   rst,
  instruction_memory_v3_if.slave bus
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_PROG = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic              prog_full_q;
  logic              record_q;
  logic              wr_evt;
  logic              addr_in_range;

`ifdef DEFAULT_PROGRAM_EN
  // Demo program image; words past the program are filled with NOP_WORD.
  function automatic logic [DATA_W-1:0] reset_word(input int unsigned idx);
    logic [11:0] w;
    case (idx)
      0:       w = 12'b010_010_000_001;
      1:       w = 12'b011_011_000_001;
      2:       w = 12'b110_000_000_111;
      3:       w = 12'b100_100_000_100;
      4:       w = 12'b110_000_000_111;
      5:       w = 12'b101_100_000_100;
      6:       w = 12'b110_000_000_111;
      7:       w = 12'b111_111_111_111;
      default: w = 12'h000;
    endcase
    return (idx < 8) ? DATA_W'(w) : NOP_WORD;
  endfunction
`else
  // Every word starts as the dummy instruction.
  function automatic logic [DATA_W-1:0] reset_word(input int unsigned idx);
    return (idx < DEPTH) ? NOP_WORD : NOP_WORD;
  endfunction
`endif

  // One write per button press: only the 0->1 transition of record counts.
  assign wr_evt        = bus.record & ~record_q;
  // Depth need not be a power of two, so the top addresses may be unbacked.
  assign addr_in_range = ({1'b0, bus.rd_addr} < (ADDR_W + 1)'(DEPTH));

  // Mode FSM, memory array, fetch port and program-load pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= reset_word(i);
      end
      state       <= S_RUN;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      wr_ptr_q    <= '0;
      prog_full_q <= 1'b0;
      record_q    <= 1'b1;
    end else begin
      record_q   <= bus.record;
      rd_valid_q <= 1'b0;
      case (state)
        S_RUN: begin
          if (bus.prog_mode) begin
            state       <= S_PROG;
            wr_ptr_q    <= '0;
            prog_full_q <= 1'b0;
          end
          if (wr_evt) begin
            if (addr_in_range) begin
              mem[bus.rd_addr] <= bus.switches;
            end
          end else if (bus.rd_en) begin
            rd_valid_q <= 1'b1;
            if (bus.isexternal) begin
              rd_data_q <= bus.switches;
            end else if (addr_in_range) begin
              rd_data_q <= mem[bus.rd_addr];
            end else begin
              rd_data_q <= NOP_WORD;
            end
          end
        end
        S_PROG: begin
          if (!bus.prog_mode) begin
            state <= S_RUN;
          end
          if (wr_evt) begin
            mem[wr_ptr_q] <= bus.switches;
            if (wr_ptr_q == LAST_ADDR) begin
              wr_ptr_q    <= '0;
              prog_full_q <= 1'b1;
            end else begin
              wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.wr_ptr    = wr_ptr_q;
  assign bus.prog_full = prog_full_q;
  assign bus.in_prog   = (state == S_PROG);

endmodule
